// File: rtl/rgb_pwm_fader.sv
// rgb_pwm_fader: ramps three LED levels toward accepted targets and drives active-low PWM pins.
// Define GAMMA_CORRECT_EN to use squared (perceptual) duty instead of linear duty.
module rgb_pwm_fader #(
  parameter int PWM_BITS = 8,
  parameter int FADE_DIV = 12000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                color_valid,
  output logic                color_ready,
  input  logic [PWM_BITS-1:0] target_r,
  input  logic [PWM_BITS-1:0] target_g,
  input  logic [PWM_BITS-1:0] target_b,
  output logic                fade_done,
  output logic                RGB_R,
  output logic                RGB_G,
  output logic                RGB_B
);
  localparam int FW = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  typedef enum logic {IDLE, FADING} state_t;
  state_t              state_q, state_d;
  logic                ready_q, ready_d, done_q, done_d;
  logic [2:0]          pin_q, pin_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [FW-1:0]       fade_cnt_q, fade_cnt_d;
  logic [PWM_BITS-1:0] level_q[3], level_d[3], target_q[3], target_d[3];
  logic [PWM_BITS-1:0] duty_q[3], duty_d[3], tgt_in[3];
  logic                accept, tick, wrap, at_target;

  always_comb begin
    tgt_in[0]  = target_r;
    tgt_in[1]  = target_g;
    tgt_in[2]  = target_b;
    accept     = color_valid && ready_q;
    tick       = fade_cnt_q == FW'(FADE_DIV - 1);
    wrap       = pwm_cnt_q == '1;
    pwm_cnt_d  = pwm_cnt_q + 1'b1;
    fade_cnt_d = (state_q == FADING && !tick) ? fade_cnt_q + 1'b1 : '0;
    at_target  = 1'b1;
    for (int i = 0; i < 3; i++) at_target = at_target && (level_q[i] == target_q[i]);
    state_d    = state_q;
    done_d     = 1'b0;
    // ready drops on accept and returns one cycle after the done pulse
    ready_d    = state_q == IDLE && !accept;
    if (state_q == IDLE && accept) state_d = FADING;
    if (state_q == FADING && at_target) begin
      state_d = IDLE;
      done_d  = 1'b1;
    end
    for (int i = 0; i < 3; i++) begin
      target_d[i] = accept ? tgt_in[i] : target_q[i];
      level_d[i]  = (state_q == FADING && tick && level_q[i] != target_q[i]) ?
                    (level_q[i] < target_q[i] ? level_q[i] + 1'b1 : level_q[i] - 1'b1) : level_q[i];
`ifdef GAMMA_CORRECT_EN
      duty_d[i]   = wrap ? PWM_BITS'(({{PWM_BITS{1'b0}}, level_q[i]} *
                                      {{PWM_BITS{1'b0}}, level_q[i]}) >> PWM_BITS) : duty_q[i];
`else
      duty_d[i]   = wrap ? level_q[i] : duty_q[i];
`endif
      pin_d[i]    = !(pwm_cnt_q < duty_q[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      pin_q      <= 3'b111;
      pwm_cnt_q  <= '0;
      fade_cnt_q <= '0;
      level_q    <= '{default: '0};
      target_q   <= '{default: '0};
      duty_q     <= '{default: '0};
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      pin_q      <= pin_d;
      pwm_cnt_q  <= pwm_cnt_d;
      fade_cnt_q <= fade_cnt_d;
      level_q    <= level_d;
      target_q   <= target_d;
      duty_q     <= duty_d;
    end
  end

  assign color_ready = ready_q;
  assign fade_done   = done_q;
  assign RGB_R       = pin_q[0];
  assign RGB_G       = pin_q[1];
  assign RGB_B       = pin_q[2];
endmodule

// File: tb/tb_rgb_pwm_fader.sv
// tb_rgb_pwm_fader: random colour targets against an edge-indexed arithmetic model
// of levels, handshake timing and per-period PWM low-time.
module tb_rgb_pwm_fader;
  logic       clk = 0, rst_n = 1, color_valid = 0;
  logic [3:0] t_r = 0, t_g = 0, t_b = 0;
  logic       color_ready, fade_done, RGB_R, RGB_G, RGB_B;
  int total = 0, bad = 0;
  int n = 0, a = 0, done_edge = -2, dmax, d, st, l, k;
  int lv0[3] = '{0, 0, 0}, tg[3] = '{0, 0, 0}, low[3] = '{0, 0, 0}, cur[3] = '{0, 0, 0};
  int hist[3][4096];
  logic pins[3];
  bit run = 0, exp_ready = 1;

  rgb_pwm_fader #(.PWM_BITS(4), .FADE_DIV(2)) dut (
    .clk(clk), .rst_n(rst_n), .color_valid(color_valid), .color_ready(color_ready),
    .target_r(t_r), .target_g(t_g), .target_b(t_b), .fade_done(fade_done),
    .RGB_R(RGB_R), .RGB_G(RGB_G), .RGB_B(RGB_B));

  always #5 clk = ~clk;

  task automatic check(string tag, int got, int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at n=%0d", tag, got, exp, n);
    end
  endtask

  function automatic int duty_of(int lv);
`ifdef GAMMA_CORRECT_EN
    return (lv * lv) >> 4;
`else
    return lv;
`endif
  endfunction

  // model: n counts clock edges since reset release; pwm count after edge n is n mod 16
  always begin
    @(posedge clk);
    #1;
    if (run) begin
      n++;
      if (color_valid && exp_ready) begin
        a    = n;
        lv0  = tg;
        tg   = '{int'(t_r), int'(t_g), int'(t_b)};
        dmax = 0;
        for (int c = 0; c < 3; c++) begin
          d = tg[c] - lv0[c];
          if (d < 0) d = -d;
          if (d > dmax) dmax = d;
        end
        done_edge = a + 1 + 2 * dmax;
      end
      exp_ready = n >= done_edge + 1;
      check("ready", color_ready, exp_ready);
      check("done", fade_done, n == done_edge);
      pins = '{RGB_R, RGB_G, RGB_B};
      for (int c = 0; c < 3; c++) begin
        d  = tg[c] - lv0[c];
        st = (n - a) / 2;
        if (st > (d < 0 ? -d : d)) st = d < 0 ? -d : d;
        l  = d < 0 ? lv0[c] - st : lv0[c] + st;
        if (n < 4096) hist[c][n] = l;
        low[c] += pins[c] ? 0 : 1;
      end
      if (n % 16 == 0) begin
        for (int c = 0; c < 3; c++) begin
          if (n >= 32 && n - 17 < 4096) check($sformatf("lowtime_ch%0d", c), low[c], duty_of(hist[c][n-17]));
          low[c] = 0;
        end
      end
    end
  end

  task automatic send(int r, int g, int b);
    int dd = 0;
    int q;
    k = 0;
    @(negedge clk);
    while (!color_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) check("ready_timeout", 0, 1);
    t_r = 4'(r); t_g = 4'(g); t_b = 4'(b);
    color_valid = 1;
    @(negedge clk);
    color_valid = 0;
    foreach (cur[c]) begin
      q = (c == 0 ? r : c == 1 ? g : b) - cur[c];
      if (q < 0) q = -q;
      if (q > dd) dd = q;
    end
    cur = '{r, g, b};
    if (dd >= 4) begin
      repeat (5) @(negedge clk);
      t_b = 4'd15; t_r = 4'($urandom_range(0, 15));
      color_valid = 1;
      @(negedge clk);
      color_valid = 0;
    end
    k = 0;
    while (!fade_done && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) check("done_timeout", 0, 1);
    repeat (40 + $urandom_range(0, 20)) @(negedge clk);
  endtask

  initial begin
    #2 rst_n = 0;
    #1;
    check("rst_pins", {RGB_R, RGB_G, RGB_B}, 7);
    check("rst_ready", color_ready, 1);
    check("rst_done", fade_done, 0);
    repeat (40) begin
      @(negedge clk);
      check("rst_hold_pins", {RGB_R, RGB_G, RGB_B}, 7);
    end
    rst_n = 1;
    run = 1;
    send(15, 0, 0);
    send(15, 15, 0);
    send(15, 15, 0);
    for (int i = 0; i < 6; i++) send($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
    send(cur[0], cur[1], cur[2]);
    send($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
    k = 0;
    while (!color_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    t_r = 4'(15 - cur[0]); t_g = 4'(15 - cur[1]); t_b = 4'(15 - cur[2]);
    color_valid = 1;
    @(negedge clk);
    color_valid = 0;
    repeat (6) @(negedge clk);
    #2 run = 0;
    rst_n = 0;
    #1;
    check("midfade_rst_pins", {RGB_R, RGB_G, RGB_B}, 7);
    check("midfade_rst_ready", color_ready, 1);
    repeat (40) begin
      @(negedge clk);
      check("midfade_rst_hold", {RGB_R, RGB_G, RGB_B, fade_done}, 14);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
